// File: rtl/qn_readout_pkg.sv
// qn_readout_pkg: shared constants, hit-word layout and FSM state type for
// the event readout block. The MARK state only exists when EVT_MARKER_EN
// is defined.
package qn_readout_pkg;

    localparam int TUBE_COUNT = 32;
    localparam int TIME_W     = 8;
    localparam int ID_W       = 8;
    localparam int IDX_W      = $clog2(TUBE_COUNT);
    localparam int HIT_CNT_W  = $clog2(TUBE_COUNT + 1);

    localparam logic [ID_W-1:0] MARKER_ID = 8'hFF;

    // One buffered word: tube number in the upper byte, tube time in the lower.
    typedef struct packed {
        logic [ID_W-1:0]   tube_id;
        logic [TIME_W-1:0] tube_time;
    } hit_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef EVT_MARKER_EN
        ST_MARK = 2'd2,
`endif
        ST_SCAN = 2'd1
    } state_e;

endpackage

// File: rtl/readout_fifo.sv
// readout_fifo: single-clock circular buffer of hit words with a registered
// empty flag. Pointers wrap modulo DEPTH (power of two); the occupancy counter
// has one extra bit so that full and empty are distinguishable.
import qn_readout_pkg::*;

module readout_fifo #(
    parameter int DEPTH = 64
) (
    input  logic      clk100,
    input  logic      rst_n,
    input  logic      push_i,
    input  hit_word_t push_data_i,
    input  logic      pop_i,
    output hit_word_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    hit_word_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = empty_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_q;

    // Occupancy next-state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage write port.
    // NOTE: the memory array has no reset; its contents are only ever read
    // behind the pointers, so clearing it would cost flops for no benefit.
    always_ff @(posedge clk100) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers, occupancy and the registered empty flag.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

endmodule

// File: rtl/event_readout.sv
// event_readout: snapshots a closed capture window, scans the 32 tubes one per
// cycle pushing {tube, time} for every hit into readout_fifo, and pops words
// to the RPi on synchronized RD_CLK rising edges. Defining EVT_MARKER_EN adds
// an end-of-event marker word {8'hFF, hit count}.
import qn_readout_pkg::*;

module event_readout #(
    parameter int FIFO_DEPTH  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk100,
    input  logic                           rst_n,
    input  logic                           evt_done,
    input  logic [0:TUBE_COUNT-1]          hit_mask,
    input  logic [0:TUBE_COUNT*TIME_W-1]   tuberad,
    output logic                           evt_busy,
    output logic [0:7]                     OTUBEN,
    output logic [0:7]                     OTUBER,
    input  logic                           RD_CLK,
    input  logic                           RD_EN,
    output logic                           RD_EMPTY,
    output logic                           RD_VALID
);

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TUBE_COUNT - 1);

    logic [1:0]             rst_sync_q;
    logic                   rst_int_n;
    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TUBE_COUNT-1:0]  mask_q;
    logic [TIME_W-1:0]      time_q [TUBE_COUNT];
    logic                   snap_en;
    logic                   push;
    hit_word_t              push_word;
    hit_word_t              head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [SYNC_STAGES-1:0] rd_clk_sync_q;
    logic [SYNC_STAGES-1:0] rd_en_sync_q;
    logic                   rd_clk_prev_q;
    logic                   read_evt;
    logic                   pop;
    logic [ID_W-1:0]        otuben_q;
    logic [TIME_W-1:0]      otuber_q;
    logic                   rd_valid_q;
`ifdef EVT_MARKER_EN
    logic [HIT_CNT_W-1:0]   hit_cnt_q;
    localparam logic [HIT_CNT_W-1:0] HIT_ONE = HIT_CNT_W'(1);
`endif

    // Reset bridge: assertion is immediate, release is aligned to clk100.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // Scan controller: accept an event in IDLE, walk the tubes, stall on full.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_en   = 1'b0;
        push      = 1'b0;
        push_word = '{tube_id: ID_W'(idx_q), tube_time: time_q[idx_q]};
        case (state_q)
            ST_IDLE: begin
                if (evt_done) begin
                    snap_en = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // A hit with nowhere to go holds the index so nothing is dropped.
                if (!mask_q[idx_q] || !fifo_full) begin
                    push  = mask_q[idx_q];
                    idx_d = idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
`ifdef EVT_MARKER_EN
                        state_d = ST_MARK;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef EVT_MARKER_EN
            ST_MARK: begin
                push_word = '{tube_id: MARKER_ID, tube_time: TIME_W'(hit_cnt_q)};
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, scan index and the hit mask snapshot.
    always_ff @(posedge clk100 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (snap_en) begin
                for (int i = 0; i < TUBE_COUNT; i++) begin
                    mask_q[i] <= hit_mask[i];
                end
            end
        end
    end

    // Tube time snapshot; only ever read at indices whose mask bit is set.
    always_ff @(posedge clk100) begin
        if (snap_en) begin
            for (int i = 0; i < TUBE_COUNT; i++) begin
                time_q[i] <= tuberad[i*TIME_W +: TIME_W];
            end
        end
    end

`ifdef EVT_MARKER_EN
    // Number of tube words pushed for the event being scanned.
    always_ff @(posedge clk100 or negedge rst_int_n) begin
        if (!rst_int_n)                      hit_cnt_q <= '0;
        else if (snap_en)                    hit_cnt_q <= '0;
        else if (push && state_q == ST_SCAN) hit_cnt_q <= hit_cnt_q + HIT_ONE;
    end
`endif

    assign evt_busy = (state_q != ST_IDLE);

    readout_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk100      (clk100),
        .rst_n       (rst_int_n),
        .push_i      (push),
        .push_data_i (push_word),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Bring the asynchronous RPi strobe and enable into clk100.
    always_ff @(posedge clk100 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rd_clk_sync_q <= '0;
            rd_en_sync_q  <= '0;
            rd_clk_prev_q <= 1'b0;
        end else begin
            rd_clk_sync_q <= {rd_clk_sync_q[SYNC_STAGES-2:0], RD_CLK};
            rd_en_sync_q  <= {rd_en_sync_q[SYNC_STAGES-2:0], RD_EN};
            rd_clk_prev_q <= rd_clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign read_evt = rd_clk_sync_q[SYNC_STAGES-1] && !rd_clk_prev_q;
    assign pop      = read_evt && rd_en_sync_q[SYNC_STAGES-1] && !fifo_empty;

    // Output word register: load on a successful pop, flag refusals.
    always_ff @(posedge clk100 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            otuben_q   <= '0;
            otuber_q   <= '0;
            rd_valid_q <= 1'b0;
        end else if (read_evt) begin
            if (pop) begin
                otuben_q   <= head.tube_id;
                otuber_q   <= head.tube_time;
                rd_valid_q <= 1'b1;
            end else begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign OTUBEN   = otuben_q;
    assign OTUBER   = otuber_q;
    assign RD_VALID = rd_valid_q;
    assign RD_EMPTY = fifo_empty;

endmodule

// File: tb/tb_event_readout.sv
// tb_event_readout: random and directed events against a queue-based model of
// the expected word stream; a monitor checks every read the RPi side performs.
module tb_event_readout;
    import qn_readout_pkg::*;

    localparam int DEPTH = 4;
`ifdef EVT_MARKER_EN
    localparam int MARK_EN = 1;
`else
    localparam int MARK_EN = 0;
`endif

    logic         clk100 = 1'b0;
    logic         rst_n = 1'b0;
    logic         evt_done = 1'b0;
    logic [0:31]  hit_mask = '0;
    logic [0:255] tuberad = '0;
    logic         evt_busy;
    logic [0:7]   OTUBEN;
    logic [0:7]   OTUBER;
    logic         RD_CLK = 1'b0;
    logic         RD_EN = 1'b0;
    logic         RD_EMPTY;
    logic         RD_VALID;

    always #5 clk100 = ~clk100;

    event_readout #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk100   (clk100),
        .rst_n    (rst_n),
        .evt_done (evt_done),
        .hit_mask (hit_mask),
        .tuberad  (tuberad),
        .evt_busy (evt_busy),
        .OTUBEN   (OTUBEN),
        .OTUBER   (OTUBER),
        .RD_CLK   (RD_CLK),
        .RD_EN    (RD_EN),
        .RD_EMPTY (RD_EMPTY),
        .RD_VALID (RD_VALID)
    );

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    bit          rd_q[$];
    logic [15:0] last_out = '0;
    logic [31:0] ev_mask;
    logic [7:0]  ev_time [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: every hit tube in ascending order, then the optional marker.
    task automatic model_event();
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (ev_mask[i]) begin
                exp_q.push_back({8'(i), ev_time[i]});
                n++;
            end
        end
        if (MARK_EN != 0) exp_q.push_back({8'hFF, 8'(n)});
    endtask

    task automatic drive_event();
        for (int i = 0; i < 32; i++) begin
            hit_mask[i]        = ev_mask[i];
            tuberad[8*i +: 8]  = ev_time[i];
        end
        @(negedge clk100) evt_done = 1'b1;
        @(negedge clk100) evt_done = 1'b0;
    endtask

    task automatic random_event();
        ev_mask = $urandom;
        for (int i = 0; i < 32; i++) ev_time[i] = 8'($urandom);
    endtask

    // One RPi read: slow strobe well above the synchronizer latency.
    task automatic read_once(input bit en, output logic valid);
        @(negedge clk100) RD_EN = en;
        repeat (3) @(negedge clk100);
        RD_CLK = 1'b1;
        repeat (4) @(negedge clk100);
        RD_CLK = 1'b0;
        repeat (2) @(negedge clk100);
        rd_q.push_back(en);
        valid = RD_VALID;
    endtask

    task automatic wait_scan(output int cyc);
        cyc = 0;
        while (evt_busy && cyc < 500) begin
            cyc++;
            @(negedge clk100);
        end
        if (cyc >= 500) check("scan_timeout", 32'(evt_busy), 32'd0);
    endtask

    // Read continuously until the scan is over and the FIFO is drained.
    task automatic drain(input string tag);
        logic v;
        int   n = 0;
        while ((evt_busy || !RD_EMPTY) && n < 200) begin
            read_once(1'b1, v);
            n++;
        end
        if (n >= 200) check({tag, "_drain_timeout"}, 32'(RD_EMPTY), 32'd1);
        repeat (2) @(negedge clk100);
        check({tag, "_empty"}, 32'(RD_EMPTY), 32'd1);
        check({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: score each completed read against the model.
    initial begin
        forever begin
            @(negedge clk100);
            if (rd_q.size() != 0) begin
                bit en;
                en = rd_q.pop_front();
                if (!en) begin
                    check("rd_valid_en0", 32'(RD_VALID), 32'd0);
                    check("hold_word_en0", {16'd0, OTUBEN, OTUBER}, {16'd0, last_out});
                end else if (RD_VALID) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%0h, want no word", {OTUBEN, OTUBER});
                    end else begin
                        last_out = exp_q.pop_front();
                        check("word", {16'd0, OTUBEN, OTUBER}, {16'd0, last_out});
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cyc;
        logic v;

        // Reset state.
        repeat (3) @(negedge clk100);
        check("rst_busy", 32'(evt_busy), 32'd0);
        check("rst_empty", 32'(RD_EMPTY), 32'd1);
        check("rst_valid", 32'(RD_VALID), 32'd0);
        check("rst_word", {16'd0, OTUBEN, OTUBER}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk100);

        // Two hits: 32-cycle scan, then two words in tube order.
        ev_mask = '0;
        for (int i = 0; i < 32; i++) ev_time[i] = 8'($urandom);
        ev_mask[3] = 1'b1;  ev_time[3]  = 8'h12;
        ev_mask[30] = 1'b1; ev_time[30] = 8'h7F;
        model_event();
        drive_event();
        wait_scan(cyc);
        check("scan_cycles", 32'(cyc), 32'(32 + MARK_EN));
        check("two_hit_not_empty", 32'(RD_EMPTY), 32'd0);
        drain("two_hit");

        // Read with RD_EN low keeps the buffered word.
        ev_mask = '0;
        ev_mask[7] = 1'b1; ev_time[7] = 8'h5A;
        model_event();
        drive_event();
        wait_scan(cyc);
        read_once(1'b0, v);
        repeat (2) @(negedge clk100);
        check("en0_retained", 32'(RD_EMPTY), 32'd0);
        drain("en0");

        // Second evt_done mid-scan with new inputs is ignored.
        random_event();
        model_event();
        drive_event();
        repeat (5) @(negedge clk100);
        random_event();
        ev_mask = 32'hFFFF_FFFF;
        drive_event();
        drain("ignore2nd");

        // Full event against a 4-deep FIFO: stall, nothing lost.
        ev_mask = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) ev_time[i] = 8'($urandom);
        model_event();
        drive_event();
        repeat (40) @(negedge clk100);
        check("stall_busy", 32'(evt_busy), 32'd1);
        check("stall_not_empty", 32'(RD_EMPTY), 32'd0);
        drain("all_hit");

        // Random events.
        for (int k = 0; k < 4; k++) begin
            random_event();
            model_event();
            drive_event();
            drain("random");
        end

        // Reset mid-scan discards everything.
        ev_mask = 32'h0000_0007;
        for (int i = 0; i < 32; i++) ev_time[i] = 8'($urandom_range(1, 255));
        model_event();
        drive_event();
        read_once(1'b1, v);
        repeat (2) @(negedge clk100);
        check("pre_rst_valid", 32'(RD_VALID), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(evt_busy), 32'd0);
        check("midrst_empty", 32'(RD_EMPTY), 32'd1);
        check("midrst_valid", 32'(RD_VALID), 32'd0);
        check("midrst_word", {16'd0, OTUBEN, OTUBER}, 32'd0);
        exp_q.delete();
        last_out = '0;
        repeat (3) @(negedge clk100);
        rst_n = 1'b1;
        repeat (5) @(negedge clk100);
        check("postrst_busy", 32'(evt_busy), 32'd0);
        read_once(1'b1, v);
        check("postrst_read_valid", 32'(v), 32'd0);
        check("postrst_empty", 32'(RD_EMPTY), 32'd1);
        repeat (3) @(negedge clk100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
